// File: rtl/deck_arbiter_pkg.sv
// Shared types and widths for the deck arbiter.
// Holds card/count/timer widths, the FSM state encoding and the round-robin step helper.
package deck_arbiter_pkg;

    localparam int CARD_W = 4;
    localparam int CNT_W  = 3;
    localparam int TMR_W  = 10;
    localparam int IDX_W  = 2;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_START      = 3'd1,
        ST_WAIT       = 3'd2,
        ST_DELIVER    = 3'd3,
        ST_SHUF_START = 3'd4,
        ST_SHUF_WAIT  = 3'd5
    } deck_arb_state_t;

    // Index of the seat after idx, wrapping at n seats.
    function automatic logic [IDX_W-1:0] rr_next(
        input logic [IDX_W-1:0] idx,
        input int               n
    );
        return (int'(idx) == n - 1) ? '0 : idx + 1'b1;
    endfunction

endpackage

// File: rtl/deck_arbiter_if.sv
// Deck dispense handshake bundle between the arbiter and the deck.
// master (arbiter): drives card_start/shuffle_start; slave (deck): drives ready/card/overflow.
interface deck_arbiter_if;
    import deck_arbiter_pkg::*;

    logic              card_start;
    logic              card_ready;
    logic [CARD_W-1:0] card;
    logic              card_overflow;
    logic              shuffle_start;
    logic              shuffle_ready;

    modport master (
        output card_start, shuffle_start,
        input  card_ready, card, card_overflow, shuffle_ready
    );

    modport slave (
        input  card_start, shuffle_start,
        output card_ready, card, card_overflow, shuffle_ready
    );

endinterface

// File: rtl/deck_arbiter_rr_pick.sv
// Combinational round-robin selector: first eligible seat at or after ptr_i.
// Ports: eligible_i, ptr_i in; idx_o (chosen seat), valid_o (any eligible) out.
module deck_arbiter_rr_pick
    import deck_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] eligible_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [IDX_W-1:0]   idx_o,
    output logic               valid_o
);

    always_comb begin
        int j;
        j       = 0;
        idx_o   = '0;
        valid_o = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (int'(ptr_i) + k) % NUM_REQ;
            if (!valid_o && eligible_i[j]) begin
                valid_o = 1'b1;
                idx_o   = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/deck_arbiter.sv
// Round-robin arbiter sharing one deck dispense handshake between NUM_REQ seats,
// with per-seat hand limit, stuck-deck timeout and overflow tracking.
// Ports: clk, rst (sync, active-high); req/clear_counts in; card_valid, req_reject,
// card_out, hand_count, hand_full, busy, timeout_err, overflow_flag out; dk = deck handshake.
// Optional reshuffle after an overflowed card: define DECK_ARB_RESHUFFLE_EN.
module deck_arbiter
    import deck_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int MAX_CARDS   = 5,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    output logic [NUM_REQ-1:0]       card_valid,
    output logic [NUM_REQ-1:0]       req_reject,
    output logic [CARD_W-1:0]        card_out,
    output logic [CNT_W*NUM_REQ-1:0] hand_count,
    output logic [NUM_REQ-1:0]       hand_full,
    input  logic                     clear_counts,
    output logic                     busy,
    output logic                     timeout_err,
    output logic                     overflow_flag,
    deck_arbiter_if.master           dk
);

    deck_arb_state_t   state_q, state_d;
    logic [IDX_W-1:0]  gnt_q, gnt_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [CARD_W-1:0] card_q, card_d;
    logic              ovf_q, ovf_d;
    logic              tout_q, tout_d;
    logic              ovff_q, ovff_d;
    logic [CNT_W-1:0]  cnt_q [NUM_REQ];
    logic [CNT_W-1:0]  cnt_d [NUM_REQ];

    logic [NUM_REQ-1:0] eligible;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_vld;
    logic               tmr_hit;
    logic               start_c;

    always_comb begin
        hand_count = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            hand_full[i]                 = (cnt_q[i] == CNT_W'(MAX_CARDS));
            hand_count[CNT_W*i +: CNT_W] = cnt_q[i];
        end
    end

    assign eligible = req & ~hand_full;
    assign tmr_hit  = (tmr_q == TMR_W'(TIMEOUT_CYC - 1));

    deck_arbiter_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .eligible_i (eligible),
        .ptr_i      (ptr_q),
        .idx_o      (pick_idx),
        .valid_o    (pick_vld)
    );

`ifdef DECK_ARB_RESHUFFLE_EN
    logic shuf_c;
    assign dk.shuffle_start = shuf_c;
`else
    logic unused_shuf_rdy;
    assign unused_shuf_rdy  = dk.shuffle_ready;
    assign dk.shuffle_start = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        ptr_d      = ptr_q;
        tmr_d      = tmr_q;
        card_d     = card_q;
        ovf_d      = ovf_q;
        tout_d     = tout_q;
        ovff_d     = ovff_q;
        cnt_d      = cnt_q;
        start_c    = 1'b0;
        card_valid = '0;
        req_reject = '0;
`ifdef DECK_ARB_RESHUFFLE_EN
        shuf_c     = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                req_reject = req & hand_full;
                if (pick_vld && dk.card_ready) begin
                    gnt_d   = pick_idx;
                    tmr_d   = '0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                start_c = 1'b1;
                if (!dk.card_ready) begin
                    tmr_d   = '0;
                    state_d = ST_WAIT;
                end else if (tmr_hit) begin
                    tout_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            ST_WAIT: begin
                if (dk.card_ready) begin
                    card_d  = dk.card;
                    ovf_d   = dk.card_overflow;
                    state_d = ST_DELIVER;
                end else if (tmr_hit) begin
                    tout_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            ST_DELIVER: begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (gnt_q == IDX_W'(i)) begin
                        card_valid[i] = 1'b1;
                        if (cnt_q[i] != CNT_W'(MAX_CARDS)) begin
                            cnt_d[i] = cnt_q[i] + 1'b1;
                        end
                    end
                end
                ptr_d   = rr_next(gnt_q, NUM_REQ);
                ovff_d  = ovff_q | ovf_q;
                state_d = ST_IDLE;
`ifdef DECK_ARB_RESHUFFLE_EN
                if (ovf_q) begin
                    tmr_d   = '0;
                    state_d = ST_SHUF_START;
                end
`endif
            end
`ifdef DECK_ARB_RESHUFFLE_EN
            ST_SHUF_START: begin
                shuf_c = 1'b1;
                if (!dk.shuffle_ready) begin
                    tmr_d   = '0;
                    state_d = ST_SHUF_WAIT;
                end else if (tmr_hit) begin
                    tout_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            ST_SHUF_WAIT: begin
                if (dk.shuffle_ready) begin
                    state_d = ST_IDLE;
                end else if (tmr_hit) begin
                    tout_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
        // A new round wins over a card counted in the same cycle.
        if (clear_counts) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            ptr_q   <= '0;
            tmr_q   <= '0;
            card_q  <= '0;
            ovf_q   <= 1'b0;
            tout_q  <= 1'b0;
            ovff_q  <= 1'b0;
            cnt_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            tmr_q   <= tmr_d;
            card_q  <= card_d;
            ovf_q   <= ovf_d;
            tout_q  <= tout_d;
            ovff_q  <= ovff_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dk.card_start = start_c;
    assign card_out      = card_q;
    assign busy          = (state_q != ST_IDLE);
    assign timeout_err   = tout_q;
    assign overflow_flag = ovff_q;

endmodule

// File: tb/tb_deck_arbiter.sv
// Self-checking bench for deck_arbiter: behavioural deck, vector table, scoreboard.
// Covers reset, latency, round-robin, hand limit, clear, overflow, timeout, mid-wait reset.
module tb_deck_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req;
    logic [1:0] card_valid;
    logic [1:0] req_reject;
    logic [3:0] card_out;
    logic [5:0] hand_count;
    logic [1:0] hand_full;
    logic       clear_counts;
    logic       busy;
    logic       timeout_err;
    logic       overflow_flag;

    deck_arbiter_if dk ();

    deck_arbiter #(
        .NUM_REQ     (2),
        .MAX_CARDS   (5),
        .TIMEOUT_CYC (1023)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .card_valid    (card_valid),
        .req_reject    (req_reject),
        .card_out      (card_out),
        .hand_count    (hand_count),
        .hand_full     (hand_full),
        .clear_counts  (clear_counts),
        .busy          (busy),
        .timeout_err   (timeout_err),
        .overflow_flag (overflow_flag),
        .dk            (dk)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [1:0] v;
        logic [3:0] c;
    } sb_t;
    sb_t sb[$];

    typedef struct {
        logic [1:0] req;
        logic [3:0] card;
        logic [1:0] ev;
        logic [1:0] er;
        logic [5:0] cnt;
    } vec_t;
    vec_t tbl[9];

    logic [3:0] next_card = 4'd0;
    logic       next_ovf  = 1'b0;
    logic       deck_hang = 1'b0;
    int         deck_dly  = 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Behavioural deck: drops card_ready on card_start, raises it deck_dly cycles later.
    initial begin
        int dly;
        int sdly;
        dly  = 0;
        sdly = 0;
        dk.card_ready    = 1'b1;
        dk.card          = '0;
        dk.card_overflow = 1'b0;
        dk.shuffle_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (!dk.card_ready) begin
                if (dly <= 1) begin
                    dk.card_ready    = 1'b1;
                    dk.card          = next_card;
                    dk.card_overflow = next_ovf;
                end else begin
                    dly--;
                end
            end else if (dk.card_start && !deck_hang) begin
                dk.card_ready = 1'b0;
                dly           = deck_dly;
            end
            if (!dk.shuffle_ready) begin
                if (sdly <= 1) dk.shuffle_ready = 1'b1;
                else sdly--;
            end else if (dk.shuffle_start) begin
                dk.shuffle_ready = 1'b0;
                sdly             = 3;
            end
        end
    end

    // Scoreboard monitor: every card_valid must match the oldest expectation.
    initial begin
        sb_t e;
        forever begin
            @(negedge clk);
            if (!rst && card_valid != 2'b00) begin
                if (sb.size() == 0) begin
                    check("unexpected card_valid", {30'd0, card_valid}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("sb card_valid", {30'd0, card_valid}, {30'd0, e.v});
                    check("sb card_out", {28'd0, card_out}, {28'd0, e.c});
                end
            end
        end
    end

    task automatic run_txn(
        input  string      nm,
        input  logic [1:0] r,
        input  logic [3:0] c,
        input  logic [1:0] ev,
        input  logic [1:0] er,
        input  logic [5:0] ecnt,
        output int         lat
    );
        int n;
        n         = 0;
        next_card = c;
        if (ev != 2'b00) sb.push_back('{ev, c});
        req = r;
        do begin
            @(negedge clk);
            n++;
        end while (card_valid == 2'b00 && req_reject == 2'b00 && n < 2000);
        if (n >= 2000) check({nm, " no response"}, 32'd1, 32'd0);
        check({nm, " reject"}, {30'd0, req_reject}, {30'd0, er});
        req = 2'b00;
        lat = n;
        @(negedge clk);
        check({nm, " counts"}, {26'd0, hand_count}, {26'd0, ecnt});
        check({nm, " idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int n;
        int starts;
        logic seen;

        tbl[0] = '{2'b11, 4'd3,  2'b01, 2'b00, {3'd0, 3'd1}};
        tbl[1] = '{2'b11, 4'd4,  2'b10, 2'b00, {3'd1, 3'd1}};
        tbl[2] = '{2'b11, 4'd5,  2'b01, 2'b00, {3'd1, 3'd2}};
        tbl[3] = '{2'b11, 4'd6,  2'b10, 2'b00, {3'd2, 3'd2}};
        tbl[4] = '{2'b01, 4'd8,  2'b01, 2'b00, {3'd2, 3'd3}};
        tbl[5] = '{2'b01, 4'd9,  2'b01, 2'b00, {3'd2, 3'd4}};
        tbl[6] = '{2'b01, 4'd10, 2'b01, 2'b00, {3'd2, 3'd5}};
        tbl[7] = '{2'b01, 4'd1,  2'b00, 2'b01, {3'd2, 3'd5}};
        tbl[8] = '{2'b10, 4'd11, 2'b10, 2'b00, {3'd3, 3'd5}};

        rst          = 1'b1;
        req          = 2'b00;
        clear_counts = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst card_valid", {30'd0, card_valid}, 32'd0);
        check("rst req_reject", {30'd0, req_reject}, 32'd0);
        check("rst card_out", {28'd0, card_out}, 32'd0);
        check("rst hand_count", {26'd0, hand_count}, 32'd0);
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst flags", {30'd0, timeout_err, overflow_flag}, 32'd0);
        check("rst starts", {30'd0, dk.card_start, dk.shuffle_start}, 32'd0);

        // Single card, deck holds ready low two cycles.
        deck_dly = 2;
        run_txn("t1", 2'b01, 4'd7, 2'b01, 2'b00, {3'd0, 3'd1}, lat);
        check("t1 latency", lat, 32'd4);
        deck_dly = 1;

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_txn($sformatf("vec%0d", i), tbl[i].req, tbl[i].card,
                    tbl[i].ev, tbl[i].er, tbl[i].cnt, lat);
        end
        check("full flags", {30'd0, hand_full}, 32'd1);

        clear_counts = 1'b1;
        @(negedge clk);
        clear_counts = 1'b0;
        check("clear counts", {26'd0, hand_count}, 32'd0);
        run_txn("after clear", 2'b01, 4'd12, 2'b01, 2'b00, {3'd0, 3'd1}, lat);

        // Overflowed card.
        next_ovf  = 1'b1;
        next_card = 4'd13;
        sb.push_back('{2'b01, 4'd13});
        req = 2'b01;
        n   = 0;
        do begin
            @(negedge clk);
            n++;
        end while (card_valid == 2'b00 && n < 2000);
        req      = 2'b00;
        next_ovf = 1'b0;
        if (n >= 2000) check("ovf no card", 32'd1, 32'd0);
`ifdef DECK_ARB_RESHUFFLE_EN
        seen = 1'b0;
        n    = 0;
        do begin
            @(negedge clk);
            n++;
            if (dk.shuffle_start) seen = 1'b1;
        end while (busy && n < 2000);
        check("ovf shuffle seen", {31'd0, seen}, 32'd1);
        check("ovf shuffle done", {31'd0, busy}, 32'd0);
`else
        @(negedge clk);
        check("ovf idle", {31'd0, busy}, 32'd0);
        check("ovf no shuffle", {31'd0, dk.shuffle_start}, 32'd0);
`endif
        check("ovf flag", {31'd0, overflow_flag}, 32'd1);
        check("ovf counts", {26'd0, hand_count}, {26'd0, 3'd0, 3'd2});
        check("ovf no tout", {31'd0, timeout_err}, 32'd0);

        // Deck never answers card_start.
        deck_hang = 1'b1;
        req       = 2'b01;
        starts    = 0;
        seen      = 1'b0;
        n         = 0;
        do begin
            @(negedge clk);
            n++;
            if (dk.card_start) starts++;
            if (busy) seen = 1'b1;
        end while (!(seen && !busy) && n < 1200);
        req       = 2'b00;
        deck_hang = 1'b0;
        check("tout cycles", starts, 32'd1023);
        check("tout err", {31'd0, timeout_err}, 32'd1);
        check("tout start low", {31'd0, dk.card_start}, 32'd0);
        check("tout counts", {26'd0, hand_count}, {26'd0, 3'd0, 3'd2});

        // Reset while waiting for the deck.
        deck_dly = 20;
        req      = 2'b10;
        n        = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!dk.card_start && n < 100);
        do begin
            @(negedge clk);
            n++;
        end while (!(busy && !dk.card_start) && n < 100);
        check("wait reached", {31'd0, busy && !dk.card_start}, 32'd1);
        rst = 1'b1;
        req = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        check("rst6 busy", {31'd0, busy}, 32'd0);
        check("rst6 start", {31'd0, dk.card_start}, 32'd0);
        check("rst6 counts", {26'd0, hand_count}, 32'd0);
        check("rst6 flags", {30'd0, timeout_err, overflow_flag}, 32'd0);
        deck_dly = 1;
        repeat (25) @(negedge clk);
        check("sb drained", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
